// File: rtl/audio_clk_gen.sv
// Programmable audio clock generator: divides clk into bclk, derives lrclk and
// single-cycle rise/fall/frame strobes, with glitch-free runtime divisor updates.
module audio_clk_gen #(
   parameter int CNT_W       = 16,
   parameter int DIV_DEFAULT = 35,
   parameter int FRAME_BITS  = 32,
   parameter int FRAME_W     = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_in,
   output logic [CNT_W-1:0] div_act,
   output logic             div_pend,
   output logic             bclk,
   output logic             bclk_rise,
   output logic             bclk_fall,
   output logic             lrclk,
   output logic             frame_strobe
);

   localparam logic [CNT_W-1:0]   DIV_RST  = CNT_W'(DIV_DEFAULT);
   localparam logic [FRAME_W-1:0] BIT_LAST = FRAME_W'(FRAME_BITS - 1);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FRAME_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   div_act_q, div_act_d;
   logic [CNT_W-1:0]   shadow_q, shadow_d;
   logic               div_pend_q, div_pend_d;
   logic               bclk_q, bclk_d;
   logic               lrclk_q, lrclk_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               frame_q, frame_d;

   logic tc;
   logic last_bit;

   assign tc       = (cnt_q == div_act_q);
   assign last_bit = (bit_cnt_q == BIT_LAST);

   always_comb begin
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      div_act_d  = div_act_q;
      shadow_d   = shadow_q;
      div_pend_d = div_pend_q;
      bclk_d     = bclk_q;
      lrclk_d    = lrclk_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      frame_d    = 1'b0;

      if (div_wr) begin
         shadow_d   = div_in;
         div_pend_d = 1'b1;
      end

      if (sync) begin
         cnt_d     = '0;
         bit_cnt_d = '0;
         bclk_d    = 1'b0;
         lrclk_d   = 1'b0;
         // The newest divisor takes effect at a phase restart.
         if (div_wr) begin
            div_act_d  = div_in;
            div_pend_d = 1'b0;
         end else if (div_pend_q) begin
            div_act_d  = shadow_q;
            div_pend_d = 1'b0;
         end
      end else if (en) begin
         if (tc) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
            rise_d = ~bclk_q;
            fall_d = bclk_q;
            if (bclk_q) begin
               if (last_bit) begin
                  bit_cnt_d = '0;
                  lrclk_d   = ~lrclk_q;
                  frame_d   = lrclk_q;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               // Divisor changes only at a period boundary, where cnt restarts at 0.
               if (div_wr) begin
                  div_act_d  = div_in;
                  div_pend_d = 1'b0;
               end else if (div_pend_q) begin
                  div_act_d  = shadow_q;
                  div_pend_d = 1'b0;
               end
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         div_act_q  <= DIV_RST;
         shadow_q   <= '0;
         div_pend_q <= 1'b0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         div_act_q  <= div_act_d;
         shadow_q   <= shadow_d;
         div_pend_q <= div_pend_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         frame_q    <= frame_d;
      end
   end

   assign div_act      = div_act_q;
   assign div_pend     = div_pend_q;
   assign bclk         = bclk_q;
   assign bclk_rise    = rise_q;
   assign bclk_fall    = fall_q;
   assign lrclk        = lrclk_q;
   assign frame_strobe = frame_q;

endmodule
